// File: rtl/vga_timing_if.sv
// Raster timing bundle: advance enable in, sync/enable/coordinate outputs.
// The generator owns the master side; pixel source and pins sit on the slave.
interface vga_timing_if #(
   parameter int CNT_W = 11
);
   logic             en;
   logic             hsync;
   logic             vsync;
   logic             de;
   logic [CNT_W-1:0] x;
   logic [CNT_W-1:0] y;
   logic             line_start;
   logic             frame_start;

   modport master (
      input  en,
      output hsync, vsync, de, x, y, line_start, frame_start
   );

   modport slave (
      output en,
      input  hsync, vsync, de, x, y, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator on the pixel clock.
// Outputs are registered one clock behind the h/v counters.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0,
   parameter int CNT_W    = 11
) (
   input  logic         clk,
   input  logic         rst,
   vga_timing_if.master vif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
   logic [CNT_W-1:0] x_q, x_d;
   logic [CNT_W-1:0] y_q, y_d;
   logic             de_q, de_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic             ls_q, ls_d;
   logic             fs_q, fs_d;
   logic             h_wrap;
   logic             v_wrap;

   assign h_wrap = (h_cnt_q == H_LAST);
   assign v_wrap = (v_cnt_q == V_LAST);

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      de_d    = de_q;
      hs_d    = hs_q;
      vs_d    = vs_q;
      ls_d    = ls_q;
      fs_d    = fs_q;
      if (vif.en) begin
         h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
         if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
         end
         // Output stage samples the pre-increment counters.
         x_d  = h_cnt_q;
         y_d  = v_cnt_q;
         de_d = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
         hs_d = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END))
              ? SYNC_POL : ~SYNC_POL;
         vs_d = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END))
              ? SYNC_POL : ~SYNC_POL;
         ls_d = (h_cnt_q == '0);
         fs_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         de_q    <= 1'b0;
         hs_q    <= ~SYNC_POL;
         vs_q    <= ~SYNC_POL;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         de_q    <= de_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
      end
   end

   assign vif.x           = x_q;
   assign vif.y           = y_q;
   assign vif.de          = de_q;
   assign vif.hsync       = hs_q;
   assign vif.vsync       = vs_q;
   assign vif.line_start  = ls_q;
   assign vif.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line timing, a scaled-down
// 15x11 raster (plus its inverted-polarity twin) for frame-level behaviour.
module tb_vga_timing_gen;

   logic clk;
   logic rst;
   logic en;

   int n_cmp;
   int n_err;

   // Small raster: H 8+2+3+2=15, V 6+1+2+2=11, frame 165 clocks.
   vga_timing_if #(.CNT_W(11)) if_f ();
   vga_timing_if #(.CNT_W(6))  if_s ();
   vga_timing_if #(.CNT_W(6))  if_p ();

   assign if_f.en = en;
   assign if_s.en = en;
   assign if_p.en = en;

   vga_timing_gen u_full (
      .clk (clk),
      .rst (rst),
      .vif (if_f)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .SYNC_POL(1'b0), .CNT_W(6)
   ) u_small (
      .clk (clk),
      .rst (rst),
      .vif (if_s)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .SYNC_POL(1'b1), .CNT_W(6)
   ) u_pol (
      .clk (clk),
      .rst (rst),
      .vif (if_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   int xbad, ybad, de_cnt, de_last0, hs_cnt, hs_first, hs_last;
   int ls_cnt, ls_prev, ls_per, fs_cnt, fs_prev, fs_per, vs_cnt;
   int de_low_rows, phs_cnt, pvs_cnt, frz_bad;

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      en    = 1'b1;

      // Reset held 4 clocks
      repeat (4) tick();
      chk("rst_x",      32'(if_f.x), 0);
      chk("rst_y",      32'(if_f.y), 0);
      chk("rst_de",     32'(if_f.de), 0);
      chk("rst_hsync",  32'(if_f.hsync), 1);
      chk("rst_vsync",  32'(if_f.vsync), 1);
      chk("rst_ls",     32'(if_f.line_start), 0);
      chk("rst_fs",     32'(if_f.frame_start), 0);
      chk("rst_pol_hs", 32'(if_p.hsync), 0);
      chk("rst_pol_vs", 32'(if_p.vsync), 0);

      // Two full-size lines
      rst = 1'b0;
      xbad = 0; ybad = 0; de_cnt = 0; de_last0 = -1;
      hs_cnt = 0; hs_first = -1; hs_last = -1;
      ls_cnt = 0; ls_prev = -1; ls_per = 0;
      fs_cnt = 0; vs_cnt = 0;
      for (int i = 0; i < 1600; i++) begin
         tick();
         if (i == 0) begin
            chk("first_fs", 32'(if_f.frame_start), 1);
            chk("first_ls", 32'(if_f.line_start), 1);
            chk("first_de", 32'(if_f.de), 1);
            chk("first_x",  32'(if_f.x), 0);
            chk("first_y",  32'(if_f.y), 0);
         end
         if (i == 1) chk("second_fs", 32'(if_f.frame_start), 0);
         if (if_f.x !== 11'(i % 800)) xbad++;
         if (if_f.y !== 11'(i / 800)) ybad++;
         if (if_f.de) begin
            de_cnt++;
            if (i < 800) de_last0 = i;
         end
         if (!if_f.hsync) begin
            hs_cnt++;
            if (i < 800) begin
               if (hs_first < 0) hs_first = i;
               hs_last = i;
            end
         end
         if (if_f.line_start) begin
            ls_cnt++;
            if (ls_prev >= 0) ls_per = i - ls_prev;
            ls_prev = i;
         end
         if (if_f.frame_start) fs_cnt++;
         if (!if_f.vsync) vs_cnt++;
      end
      chk("line_xseq",    32'(xbad), 0);
      chk("line_yseq",    32'(ybad), 0);
      chk("line_de_cnt",  32'(de_cnt), 1280);
      chk("line_de_last", 32'(de_last0), 639);
      chk("line_hs_cnt",  32'(hs_cnt), 192);
      chk("line_hs_beg",  32'(hs_first), 656);
      chk("line_hs_end",  32'(hs_last), 751);
      chk("line_ls_cnt",  32'(ls_cnt), 2);
      chk("line_ls_per",  32'(ls_per), 800);
      chk("line_fs_cnt",  32'(fs_cnt), 1);
      chk("line_vs_cnt",  32'(vs_cnt), 0);

      // Two small frames
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      xbad = 0; ybad = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
      ls_cnt = 0; fs_cnt = 0; fs_prev = -1; fs_per = 0;
      de_low_rows = 0; phs_cnt = 0; pvs_cnt = 0;
      for (int i = 0; i < 330; i++) begin
         tick();
         if (if_s.x !== 6'(i % 15)) xbad++;
         if (if_s.y !== 6'((i / 15) % 11)) ybad++;
         if (if_s.de) begin
            de_cnt++;
            if (if_s.y >= 6) de_low_rows++;
         end
         if (!if_s.hsync) hs_cnt++;
         if (!if_s.vsync) begin
            vs_cnt++;
            if (if_s.y < 7 || if_s.y > 8) de_low_rows++;
         end
         if (if_p.hsync) phs_cnt++;
         if (if_p.vsync) pvs_cnt++;
         if (if_s.line_start) ls_cnt++;
         if (if_s.frame_start) begin
            fs_cnt++;
            if (fs_prev >= 0) fs_per = i - fs_prev;
            fs_prev = i;
         end
      end
      chk("frm_xseq",   32'(xbad), 0);
      chk("frm_yseq",   32'(ybad), 0);
      chk("frm_de_cnt", 32'(de_cnt), 96);
      chk("frm_stray",  32'(de_low_rows), 0);
      chk("frm_hs_cnt", 32'(hs_cnt), 66);
      chk("frm_vs_cnt", 32'(vs_cnt), 60);
      chk("frm_ls_cnt", 32'(ls_cnt), 22);
      chk("frm_fs_cnt", 32'(fs_cnt), 2);
      chk("frm_fs_per", 32'(fs_per), 165);
      chk("pol_hs_cnt", 32'(phs_cnt), 66);
      chk("pol_vs_cnt", 32'(pvs_cnt), 60);

      // Freeze 37 clocks: full at x=300, small at x=0,y=9
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (301) tick();
      chk("pre_frz_fx",  32'(if_f.x), 300);
      chk("pre_frz_sy",  32'(if_s.y), 9);
      chk("pre_frz_sls", 32'(if_s.line_start), 1);
      en = 1'b0;
      frz_bad = 0;
      for (int i = 0; i < 37; i++) begin
         tick();
         if (if_f.x !== 11'd300 || if_f.y !== 11'd0) frz_bad++;
         if (if_f.de !== 1'b1 || if_f.hsync !== 1'b1) frz_bad++;
         if (if_s.x !== 6'd0 || if_s.y !== 6'd9) frz_bad++;
         if (if_s.line_start !== 1'b1 || if_s.de !== 1'b0) frz_bad++;
      end
      chk("frz_hold", 32'(frz_bad), 0);
      en = 1'b1;
      tick();
      chk("resume_fx",  32'(if_f.x), 301);
      chk("resume_fy",  32'(if_f.y), 0);
      chk("resume_sx",  32'(if_s.x), 1);
      chk("resume_sls", 32'(if_s.line_start), 0);

      // Reset mid-sync: small at x=11,y=8
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (132) tick();
      chk("mid_sx",  32'(if_s.x), 11);
      chk("mid_sy",  32'(if_s.y), 8);
      chk("mid_shs", 32'(if_s.hsync), 0);
      chk("mid_svs", 32'(if_s.vsync), 0);
      chk("mid_phs", 32'(if_p.hsync), 1);
      chk("mid_pvs", 32'(if_p.vsync), 1);
      rst = 1'b1;
      tick();
      chk("rst1_shs", 32'(if_s.hsync), 1);
      chk("rst1_svs", 32'(if_s.vsync), 1);
      chk("rst1_phs", 32'(if_p.hsync), 0);
      chk("rst1_pvs", 32'(if_p.vsync), 0);
      chk("rst1_sx",  32'(if_s.x), 0);
      chk("rst1_sy",  32'(if_s.y), 0);
      rst = 1'b0;
      tick();
      chk("rst1_fs",  32'(if_s.frame_start), 1);
      chk("rst1_de",  32'(if_s.de), 1);
      chk("rst1_ffs", 32'(if_f.frame_start), 1);
      tick();
      chk("rst1_x1",  32'(if_s.x), 1);
      chk("rst1_fs2", 32'(if_s.frame_start), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
